// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (memory-first, with an ALU
// starvation guard), plus a busy-bit scoreboard for read-after-write hazard queries.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluRd,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memRd,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueRd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1Busy,
    output logic                  rs2Busy,
    output logic                  rfWriteEnable,
    output logic [ADDR_WIDTH-1:0] rfWriteRegister,
    output logic [DATA_WIDTH-1:0] rfWriteData
);

    localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 starved;
    logic                 alu_grant;
    logic                 mem_grant;
    logic [NUM_REGS-1:0]  busy;

    // Memory wins contention unless the ALU has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        starved   = (starve_cnt == STARVE_MAX);
        alu_grant = resetN && aluValid && (!memValid || starved);
        mem_grant = resetN && memValid && !alu_grant;
    end

    assign aluReady = alu_grant;
    assign memReady = mem_grant;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            starve_cnt <= '0;
        end else if (!aluValid || alu_grant) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Writes to register 0 still complete the handshake but never reach the register file.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rfWriteEnable   <= 1'b0;
            rfWriteRegister <= '0;
            rfWriteData     <= '0;
        end else if (alu_grant) begin
            rfWriteEnable   <= (aluRd != '0);
            rfWriteRegister <= aluRd;
            rfWriteData     <= aluData;
        end else if (mem_grant) begin
            rfWriteEnable   <= (memRd != '0);
            rfWriteRegister <= memRd;
            rfWriteData     <= memData;
        end else begin
            rfWriteEnable   <= 1'b0;
        end
    end

    // A new issue to the same register overrides the completing writeback: the newer producer is still outstanding.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (issueValid && (issueRd == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b1;
                end else if (rfWriteEnable && (rfWriteRegister == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign rs1Busy = busy[rs1];
    assign rs2Busy = busy[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter, checked against a cycle-level
// behavioural model of the writeback port, the starvation rule and the scoreboard.
module tb_regfile_wb_arbiter;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int STARVE = 3;
    localparam int NREGS  = 2 ** AW;

    logic          clk;
    logic          resetN;
    logic          aluValid, memValid, issueValid;
    logic [AW-1:0] aluRd, memRd, issueRd, rs1, rs2;
    logic [DW-1:0] aluData, memData;
    logic          aluReady, memReady, rs1Busy, rs2Busy;
    logic          rfWriteEnable;
    logic [AW-1:0] rfWriteRegister;
    logic [DW-1:0] rfWriteData;

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state
    bit            m_we;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    int            m_denied;
    bit            m_busy [NREGS];

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .resetN(resetN),
        .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memRd(memRd), .memData(memData), .memReady(memReady),
        .issueValid(issueValid), .issueRd(issueRd),
        .rs1(rs1), .rs2(rs2), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
        .rfWriteEnable(rfWriteEnable), .rfWriteRegister(rfWriteRegister), .rfWriteData(rfWriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        m_we = 0; m_reg = '0; m_data = '0; m_denied = 0;
        for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    endtask

    // Drives one cycle of inputs, checks all outputs against the model, then advances the model across the edge.
    task automatic applyStimulus(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                                 input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                                 input bit iv, input logic [AW-1:0] ird,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit exp_alu, exp_mem;
        aluValid = av; aluRd = ard; aluData = ad;
        memValid = mv; memRd = mrd; memData = md;
        issueValid = iv; issueRd = ird; rs1 = r1; rs2 = r2;
        #1;
        exp_alu = av && (!mv || m_denied >= STARVE);
        exp_mem = mv && !exp_alu;
        checkOutput("aluReady", aluReady, exp_alu);
        checkOutput("memReady", memReady, exp_mem);
        checkOutput("rs1Busy", rs1Busy, m_busy[r1]);
        checkOutput("rs2Busy", rs2Busy, m_busy[r2]);
        checkOutput("rfWriteEnable", rfWriteEnable, m_we);
        if (m_we) begin
            checkOutput("rfWriteRegister", rfWriteRegister, m_reg);
            checkOutput("rfWriteData", rfWriteData, m_data);
        end
        @(posedge clk);
        if (m_we) m_busy[m_reg] = 0;
        if (iv && ird != 0) m_busy[ird] = 1;
        if (exp_alu) begin
            m_we = (ard != 0); m_reg = ard; m_data = ad;
        end else if (exp_mem) begin
            m_we = (mrd != 0); m_reg = mrd; m_data = md;
        end else begin
            m_we = 0;
        end
        m_denied = (av && !exp_alu) ? ((m_denied < STARVE) ? m_denied + 1 : STARVE) : 0;
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        resetN = 1'b0;
        aluValid = 0; aluRd = '0; aluData = '0;
        memValid = 0; memRd = '0; memData = '0;
        issueValid = 0; issueRd = '0; rs1 = '0; rs2 = '0;
        modelReset();
        #1;
        checkOutput("reset_we", rfWriteEnable, 1'b0);
        checkOutput("reset_reg", rfWriteRegister, '0);
        checkOutput("reset_data", rfWriteData, '0);
        @(negedge clk);
        resetN = 1'b1;

        $display("[TB] single source");
        applyStimulus(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        $display("[TB] contention and starvation");
        for (int k = 0; k < 6; k++)
            applyStimulus(1, AW'(k + 1), 32'hA000_0000 + k, 1, AW'(k + 16), 32'hB000_0000 + k, 0, 0, 0, 0);
        idle(0, 0);

        $display("[TB] x0 discard");
        applyStimulus(0, 0, 0, 1, 0, 32'h1234_5678, 0, 0, 0, 0);
        idle(0, 0);

        $display("[TB] scoreboard");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        idle(0, 9);
        applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 9);
        idle(0, 9);
        idle(0, 9);

        $display("[TB] set/clear collision");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        applyStimulus(1, 12, 32'hC0C0, 0, 0, 0, 0, 0, 12, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        idle(12, 0);
        idle(12, 0);

        $display("[TB] reset mid-write");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        applyStimulus(0, 0, 0, 1, 5, 32'h5555, 0, 0, 5, 0);
        aluValid = 1; memValid = 1;
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("mid_reset_we", rfWriteEnable, 1'b0);
        checkOutput("mid_reset_reg", rfWriteRegister, '0);
        checkOutput("mid_reset_data", rfWriteData, '0);
        checkOutput("mid_reset_aluReady", aluReady, 1'b0);
        checkOutput("mid_reset_memReady", memReady, 1'b0);
        modelReset();
        @(negedge clk);
        resetN = 1'b1;
        idle(5, 5);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            applyStimulus(($urandom % 4) != 0, AW'($urandom_range(0, 15)), $urandom,
                          ($urandom % 3) != 0, AW'($urandom_range(0, 15)), $urandom,
                          ($urandom % 2) != 0, AW'($urandom_range(0, 15)),
                          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the ALU result path and the load/memory result path.
- Both sources use a valid/ready handshake. Fixed priority goes to the memory source, with a starvation guard for the ALU source.
- Drives the register file's writeEnable, writeRegister and writeData from registered outputs.
- Keeps a busy-bit scoreboard of registers with outstanding writes, so issue logic can detect read-after-write hazards.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers; register 0 hardwired to zero).
- STARVE_LIMIT, 3, consecutive denied ALU cycles after which the ALU gets priority for one grant.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- aluValid  in  1  ALU writeback request.
- aluRd  in  ADDR_WIDTH  ALU destination register.
- aluData  in  DATA_WIDTH  ALU result.
- aluReady  out  1  ALU request accepted this cycle (combinational).
- memValid  in  1  memory writeback request.
- memRd  in  ADDR_WIDTH  memory destination register.
- memData  in  DATA_WIDTH  load result.
- memReady  out  1  memory request accepted this cycle (combinational).
- issueValid  in  1  an instruction with a destination register is issued.
- issueRd  in  ADDR_WIDTH  destination of the issued instruction.
- rs1  in  ADDR_WIDTH  hazard query index 1.
- rs2  in  ADDR_WIDTH  hazard query index 2.
- rs1Busy  out  1  rs1 has an outstanding write (combinational).
- rs2Busy  out  1  rs2 has an outstanding write (combinational).
- rfWriteEnable  out  1  to register file writeEnable.
- rfWriteRegister  out  ADDR_WIDTH  to register file writeRegister.
- rfWriteData  out  DATA_WIDTH  to register file writeData.

Behaviour:
- **Reset (resetN low, asynchronous):**
  - rfWriteEnable=0, rfWriteRegister=0, rfWriteData=0.
  - All busy bits = 0; starvation counter = 0.
  - A write pending in the output register is dropped immediately.
  - aluReady and memReady are 0 while resetN is low.
- **Arbitration (combinational, one grant per cycle):**
  - Only one valid: that source is granted.
  - Both valid and counter < STARVE_LIMIT: memory is granted.
  - Both valid and counter == STARVE_LIMIT: ALU is granted.
  - Ready is asserted only to the granted source. A transfer occurs when valid and ready are both high in the same cycle.
- **Starvation counter:**
  - Increments (saturating at STARVE_LIMIT) each cycle aluValid=1 and aluReady=0.
  - Clears on any ALU grant, or any cycle with aluValid=0.
- **Latency:**
  - A grant at edge N loads the output register. rfWriteEnable/rfWriteRegister/rfWriteData are valid during cycle N+1.
  - The register file commits at edge N+1.
  - Throughput is one write per cycle.
- **No-grant cycle:** rfWriteEnable=0 next cycle. rfWriteRegister/rfWriteData hold their previous values.
- **Register 0:** a granted request with rd=0 completes its handshake but produces rfWriteEnable=0 (write discarded).
- **Scoreboard (one busy bit per register 1..2**ADDR_WIDTH-1; bit 0 constant 0):**
  - Set: at the edge where issueValid=1 and issueRd!=0.
  - Clear: at the edge that ends a cycle with rfWriteEnable=1, for rfWriteRegister. The register stays busy during the cycle the write is on the port.
  - Same register set and cleared at the same edge: set wins (a newer producer is outstanding).
  - Setting an already-busy register is legal; it remains busy. No counting — a single writeback clears it.
  - rsXBusy = busy[rsX]; rs=0 always returns 0.
- Simultaneous issue, grant and query in one cycle are independent; no mutual blocking.

Test Plan:
1. **Reset:** resetN low mid-write (rfWriteEnable=1, rd=5) -> outputs immediately 0; rs1=5 after release -> rs1Busy=0.
2. **Single source:** aluValid=1, aluRd=7, aluData=0xDEADBEEF at edge N -> aluReady=1 in cycle N; cycle N+1 rfWriteEnable=1, rfWriteRegister=7, rfWriteData=0xDEADBEEF; cycle N+2 rfWriteEnable=0.
3. **Contention and starvation (STARVE_LIMIT=3):** both valid continuously -> grants mem, mem, mem, then ALU on cycle 4, then mem again. Port shows one write per cycle with correct rd/data order.
4. **x0 discard:** memValid=1, memRd=0 -> memReady=1, rfWriteEnable stays 0.
5. **Scoreboard:**
   - issueValid with issueRd=9 -> rs2=9 gives rs2Busy=1 next cycle.
   - ALU writeback to 9 -> rs2Busy stays 1 during the rfWriteEnable cycle and drops to 0 one cycle later.
6. **Set/clear collision:** rfWriteEnable=1 to rd=12 while issueValid=1, issueRd=12 -> busy[12] remains 1 after the edge.
